// File: rtl/cla_pkg.sv
// Shared types and sizing helpers for the sliced carry-lookahead add/subtract sequencer.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF  = 64;
  localparam int SLICE_DEF  = 16;
  localparam int NSLICE_DEF = WIDTH_DEF / SLICE_DEF;

  // Counter needs at least one bit even when a single slice covers the whole word.
  function automatic int cnt_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(NSLICE_DEF);

endpackage

// File: rtl/cla_slice.sv
// Combinational carry-lookahead slice: per-bit generate/propagate, lookahead carries,
// sum bits, carry out and the slice-level group generate/propagate.
module cla_slice #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] i_x,
  input  logic [SLICE-1:0] i_y,
  input  logic             i_cin,
  output logic [SLICE-1:0] o_s,
  output logic             o_cout,
  output logic             o_g,
  output logic             o_p
);

  logic [SLICE-1:0] w_g;
  logic [SLICE-1:0] w_p;

  assign w_g = i_x & i_y;
  assign w_p = i_x ^ i_y;

  always_comb begin
    logic [SLICE:0] w_c;
    logic           w_grp;
    w_c    = '0;
    w_c[0] = i_cin;
    w_grp  = 1'b0;
    for (int i = 0; i < SLICE; i++) begin
      w_c[i+1] = w_g[i] | (w_c[i] & w_p[i]);
      // Group generate is the carry out this slice would produce with a zero carry in.
      w_grp    = w_g[i] | (w_grp & w_p[i]);
    end
    o_s    = w_p ^ w_c[SLICE-1:0];
    o_cout = w_c[SLICE];
    o_g    = w_grp;
    o_p    = &w_p;
  end

endmodule

// File: rtl/cla_add_sequencer.sv
// Multi-cycle add/subtract: one shared CLA slice processes SLICE bits per cycle,
// with the inter-slice carry held in a register. One operation in flight at a time.
module cla_add_sequencer
  import cla_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output state_t           o_dbg_state
);

  localparam int NSLICE = (SLICE > 0) ? (WIDTH / SLICE) : 1;
  localparam int CNT_W  = cnt_width(NSLICE);

  generate
    if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
      $error("cla_add_sequencer: WIDTH must be a non-zero multiple of SLICE");
    end
  endgenerate

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and in_ready/out_valid are never high together.
  state_t                       r_state;
  state_t                       w_state_next;
  logic [NSLICE-1:0][SLICE-1:0] r_a;
  logic [NSLICE-1:0][SLICE-1:0] r_b;
  logic [NSLICE-1:0][SLICE-1:0] r_sum;
  logic [NSLICE-1:0][SLICE-1:0] w_sum_next;
  logic [CNT_W-1:0]             r_cnt;
  logic                         r_carry;
  logic                         r_cout;
  logic                         r_ovf;
  logic                         r_zero;
  logic                         w_accept;
  logic                         w_step;
  logic                         w_last;
  logic [SLICE-1:0]             w_s;
  logic                         w_cout;
  logic                         w_grp_g;
  logic                         w_grp_p;

  cla_slice #(.SLICE(SLICE)) u_slice (
    .i_x    (r_a[r_cnt]),
    .i_y    (r_b[r_cnt]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout),
    .o_g    (w_grp_g),
    .o_p    (w_grp_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_last       = (r_cnt == CNT_W'(NSLICE - 1));
    case (r_state)
      IDLE: begin
        busy     = 1'b0;
        // Held low while reset is asserted so nothing looks acceptable during reset.
        in_ready = rst_n;
        if (in_valid && rst_n) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: begin
        busy         = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    w_sum_next        = r_sum;
    w_sum_next[r_cnt] = w_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + 1: invert B once and seed the carry with sub.
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_sum   <= w_sum_next;
      r_carry <= w_grp_g | (w_grp_p & r_carry);
      if (w_last) begin
        r_cnt  <= '0;
        r_cout <= w_cout;
        r_ovf  <= (r_a[NSLICE-1][SLICE-1] == r_b[NSLICE-1][SLICE-1]) &
                  (w_s[SLICE-1] != r_a[NSLICE-1][SLICE-1]);
        r_zero <= ~|w_sum_next;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign sum         = r_sum;
  assign cout        = r_cout;
  assign ovf         = r_ovf;
  assign zero        = r_zero;
  assign o_dbg_state = r_state;

endmodule
